// File: rtl/rf_io_ctrl.sv
// rf_io_ctrl: register-mapped I/O controller on SPI chip-select slot 1.
// Decodes fetch/load strobes into a small register file and drives LEDs,
// PMOD, mixer controls and the RF front-end switch/LNA-shutdown lines.
// Optional feature macro: IOC_INPUT_SYNC_EN adds a two-flop synchronizer
// on the button and configuration-strap inputs.
module rf_io_ctrl #(
  parameter logic [7:0] VERSION = 8'h01
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic [4:0] i_ioc,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_data_out,
  input  logic       i_cs,
  input  logic       i_fetch_cmd,
  input  logic       i_load_cmd,
  input  logic       i_button,
  input  logic [3:0] i_config,
  output logic       o_led0,
  output logic       o_led1,
  output logic [7:0] o_pmod,
  output logic       o_mixer_fm,
  output logic       o_mixer_en,
  output logic       o_rx_h_tx_l,
  output logic       o_rx_h_tx_l_b,
  output logic       o_tr_vc1,
  output logic       o_tr_vc1_b,
  output logic       o_tr_vc2,
  output logic       o_shdn_rx_lna,
  output logic       o_shdn_tx_lna
);

  localparam logic [4:0] ADDR_VERSION = 5'h00;
  localparam logic [4:0] ADDR_LED     = 5'h01;
  localparam logic [4:0] ADDR_PMOD    = 5'h02;
  localparam logic [4:0] ADDR_INPUTS  = 5'h03;
  localparam logic [4:0] ADDR_MIXER   = 5'h04;
  localparam logic [4:0] ADDR_RF_MODE = 5'h05;

  typedef enum logic [2:0] {
    MODE_LOW_PWR    = 3'd0,
    MODE_RX_BYPASS  = 3'd1,
    MODE_RX_LOWPASS = 3'd2,
    MODE_RX_HIPASS  = 3'd3,
    MODE_TX_BYPASS  = 3'd4,
    MODE_TX_LOWPASS = 3'd5,
    MODE_TX_HIPASS  = 3'd6,
    MODE_SPARE      = 3'd7
  } rf_mode_e;

  logic [1:0] led_q, led_d;
  logic [7:0] pmod_q, pmod_d;
  logic       mixer_fm_q, mixer_fm_d;
  logic [2:0] mode_q, mode_d;
  logic [7:0] data_out_q, data_out_d;
  logic [4:0] inputs_s;
  logic [7:0] rd_val;
  logic       wr_en;
  logic       rd_en;

`ifdef IOC_INPUT_SYNC_EN
  logic [4:0] sync_meta_q, sync_meta_d;
  logic [4:0] sync_out_q, sync_out_d;

  // Two-stage synchronizer shift for {config, button}
  always_comb begin
    sync_meta_d = {i_config, i_button};
    sync_out_d  = sync_meta_q;
  end

  // Synchronizer flops, cleared on reset
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      sync_meta_q <= 5'd0;
      sync_out_q  <= 5'd0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_out_q  <= sync_out_d;
    end
  end

  assign inputs_s = sync_out_q;
`else
  assign inputs_s = {i_config, i_button};
`endif

  assign wr_en = i_cs & i_load_cmd;
  assign rd_en = i_cs & i_fetch_cmd;

  // Read mux over current register contents (a same-cycle write is not yet visible)
  always_comb begin
    rd_val = 8'h00;
    case (i_ioc)
      ADDR_VERSION: rd_val = VERSION;
      ADDR_LED:     rd_val = {6'd0, led_q};
      ADDR_PMOD:    rd_val = pmod_q;
      ADDR_INPUTS:  rd_val = {3'd0, inputs_s};
      ADDR_MIXER:   rd_val = {7'd0, mixer_fm_q};
      ADDR_RF_MODE: rd_val = {5'd0, mode_q};
      default:      rd_val = 8'h00;
    endcase
  end

  // Next-state for RW registers and the read-data holding register
  always_comb begin
    led_d      = led_q;
    pmod_d     = pmod_q;
    mixer_fm_d = mixer_fm_q;
    mode_d     = mode_q;
    data_out_d = data_out_q;
    if (wr_en) begin
      case (i_ioc)
        ADDR_LED:     led_d      = i_data_in[1:0];
        ADDR_PMOD:    pmod_d     = i_data_in;
        ADDR_MIXER:   mixer_fm_d = i_data_in[0];
        ADDR_RF_MODE: mode_d     = i_data_in[2:0];
        default:      ;
      endcase
    end
    if (rd_en) begin
      data_out_d = rd_val;
    end
  end

  // Register file and read-data flops with asynchronous clear
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      led_q      <= 2'd0;
      pmod_q     <= 8'h00;
      mixer_fm_q <= 1'b0;
      mode_q     <= 3'd0;
      data_out_q <= 8'h00;
    end else begin
      led_q      <= led_d;
      pmod_q     <= pmod_d;
      mixer_fm_q <= mixer_fm_d;
      mode_q     <= mode_d;
      data_out_q <= data_out_d;
    end
  end

  // RF front-end decode straight from the mode flops so reset lands in LOW_PWR at once
  always_comb begin
    o_rx_h_tx_l   = 1'b1;
    o_tr_vc1      = 1'b0;
    o_tr_vc2      = 1'b0;
    o_shdn_rx_lna = 1'b1;
    o_shdn_tx_lna = 1'b1;
    o_mixer_en    = 1'b0;
    case (rf_mode_e'(mode_q))
      MODE_RX_BYPASS: begin
        o_tr_vc1 = 1'b1; o_shdn_rx_lna = 1'b0;
      end
      MODE_RX_LOWPASS: begin
        o_tr_vc2 = 1'b1; o_shdn_rx_lna = 1'b0; o_mixer_en = 1'b1;
      end
      MODE_RX_HIPASS: begin
        o_tr_vc1 = 1'b1; o_tr_vc2 = 1'b1; o_shdn_rx_lna = 1'b0; o_mixer_en = 1'b1;
      end
      MODE_TX_BYPASS: begin
        o_rx_h_tx_l = 1'b0; o_tr_vc1 = 1'b1; o_shdn_tx_lna = 1'b0;
      end
      MODE_TX_LOWPASS: begin
        o_rx_h_tx_l = 1'b0; o_tr_vc2 = 1'b1; o_shdn_tx_lna = 1'b0; o_mixer_en = 1'b1;
      end
      MODE_TX_HIPASS: begin
        o_rx_h_tx_l = 1'b0; o_tr_vc1 = 1'b1; o_tr_vc2 = 1'b1; o_shdn_tx_lna = 1'b0;
        o_mixer_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_rx_h_tx_l_b = ~o_rx_h_tx_l;
  assign o_tr_vc1_b    = ~o_tr_vc1;
  assign o_data_out    = data_out_q;
  assign o_led0        = led_q[0];
  assign o_led1        = led_q[1];
  assign o_pmod        = pmod_q;
  assign o_mixer_fm    = mixer_fm_q;

endmodule

// File: tb/tb_rf_io_ctrl.sv
// Testbench for rf_io_ctrl: directed register accesses with hand-computed
// expectations, RF mode decode sweep, input readback and async reset.
module tb_rf_io_ctrl;

  logic       i_sys_clk = 1'b0;
  logic       i_rst_b;
  logic [4:0] i_ioc;
  logic [7:0] i_data_in;
  logic [7:0] o_data_out;
  logic       i_cs;
  logic       i_fetch_cmd;
  logic       i_load_cmd;
  logic       i_button;
  logic [3:0] i_config;
  logic       o_led0, o_led1;
  logic [7:0] o_pmod;
  logic       o_mixer_fm, o_mixer_en;
  logic       o_rx_h_tx_l, o_rx_h_tx_l_b;
  logic       o_tr_vc1, o_tr_vc1_b, o_tr_vc2;
  logic       o_shdn_rx_lna, o_shdn_tx_lna;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected {rx_h_tx_l, vc1, vc2, shdn_rx, shdn_tx, mixer_en} per mode
  logic [5:0] mode_exp [8] = '{6'b100110, 6'b110010, 6'b101011, 6'b111011,
                               6'b010100, 6'b001101, 6'b011101, 6'b100110};

  rf_io_ctrl #(.VERSION(8'h01)) dut (
    .i_sys_clk     (i_sys_clk),
    .i_rst_b       (i_rst_b),
    .i_ioc         (i_ioc),
    .i_data_in     (i_data_in),
    .o_data_out    (o_data_out),
    .i_cs          (i_cs),
    .i_fetch_cmd   (i_fetch_cmd),
    .i_load_cmd    (i_load_cmd),
    .i_button      (i_button),
    .i_config      (i_config),
    .o_led0        (o_led0),
    .o_led1        (o_led1),
    .o_pmod        (o_pmod),
    .o_mixer_fm    (o_mixer_fm),
    .o_mixer_en    (o_mixer_en),
    .o_rx_h_tx_l   (o_rx_h_tx_l),
    .o_rx_h_tx_l_b (o_rx_h_tx_l_b),
    .o_tr_vc1      (o_tr_vc1),
    .o_tr_vc1_b    (o_tr_vc1_b),
    .o_tr_vc2      (o_tr_vc2),
    .o_shdn_rx_lna (o_shdn_rx_lna),
    .o_shdn_tx_lna (o_shdn_tx_lna)
  );

  // Free-running 100 MHz clock
  always #5 i_sys_clk = ~i_sys_clk;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // One-cycle strobe driven between edges; returns at the following negedge
  task automatic applyStimulus(input logic cs, input logic ld, input logic fe,
                               input logic [4:0] addr, input logic [7:0] data);
    @(negedge i_sys_clk);
    i_cs = cs; i_load_cmd = ld; i_fetch_cmd = fe; i_ioc = addr; i_data_in = data;
    @(negedge i_sys_clk);
    i_cs = 1'b0; i_load_cmd = 1'b0; i_fetch_cmd = 1'b0;
  endtask

  function automatic logic [7:0] rf_vec();
    return {2'b00, o_rx_h_tx_l, o_tr_vc1, o_tr_vc2, o_shdn_rx_lna, o_shdn_tx_lna, o_mixer_en};
  endfunction

  function automatic logic [7:0] comp_vec();
    return {6'd0, o_rx_h_tx_l ^ o_rx_h_tx_l_b, o_tr_vc1 ^ o_tr_vc1_b};
  endfunction

  initial begin
    i_rst_b = 1'b0; i_cs = 1'b0; i_load_cmd = 1'b0; i_fetch_cmd = 1'b0;
    i_ioc = 5'd0; i_data_in = 8'd0; i_button = 1'b0; i_config = 4'd0;
    repeat (2) @(negedge i_sys_clk);
    checkOutput("reset_data_out", o_data_out, 8'h00);
    checkOutput("reset_rf", rf_vec(), {2'b00, mode_exp[0]});
    checkOutput("reset_misc", {4'd0, o_led1, o_led0, o_mixer_fm, 1'b0}, 8'h00);
    checkOutput("reset_pmod", o_pmod, 8'h00);
    i_rst_b = 1'b1;

    applyStimulus(1, 0, 1, 5'h00, 8'h00);
    checkOutput("rd_version", o_data_out, 8'h01);
    applyStimulus(1, 0, 1, 5'h01, 8'h00);
    checkOutput("rd_led_reset", o_data_out, 8'h00);
    applyStimulus(1, 0, 1, 5'h05, 8'h00);
    checkOutput("rd_mode_reset", o_data_out, 8'h00);

    applyStimulus(1, 1, 0, 5'h01, 8'hFF);
    checkOutput("led_outputs", {6'd0, o_led1, o_led0}, 8'h03);
    applyStimulus(1, 0, 1, 5'h01, 8'h00);
    checkOutput("rd_led", o_data_out, 8'h03);
    applyStimulus(1, 1, 0, 5'h02, 8'hA5);
    checkOutput("pmod_out", o_pmod, 8'hA5);
    applyStimulus(1, 0, 1, 5'h02, 8'h00);
    checkOutput("rd_pmod", o_data_out, 8'hA5);
    applyStimulus(1, 1, 0, 5'h04, 8'hFF);
    checkOutput("mixer_fm", {7'd0, o_mixer_fm}, 8'h01);
    applyStimulus(1, 0, 1, 5'h04, 8'h00);
    checkOutput("rd_mixer", o_data_out, 8'h01);

    // Fetch and load to the same address in one cycle: old value returned, write lands
    applyStimulus(1, 1, 1, 5'h02, 8'h11);
    checkOutput("rw_same_rd", o_data_out, 8'hA5);
    checkOutput("rw_same_wr", o_pmod, 8'h11);

    for (int m = 0; m < 8; m++) begin
      applyStimulus(1, 1, 0, 5'h05, 8'(m) | 8'hF8);
      checkOutput($sformatf("mode%0d_rf", m), rf_vec(), {2'b00, mode_exp[m]});
      checkOutput($sformatf("mode%0d_comp", m), comp_vec(), 8'h03);
    end
    applyStimulus(1, 0, 1, 5'h05, 8'h00);
    checkOutput("rd_mode7", o_data_out, 8'h07);

`ifdef IOC_INPUT_SYNC_EN
    @(negedge i_sys_clk);
    i_button = 1'b1; i_config = 4'b1010;
    i_cs = 1'b1; i_fetch_cmd = 1'b1; i_ioc = 5'h03;
    @(negedge i_sys_clk);
    i_cs = 1'b0; i_fetch_cmd = 1'b0;
    checkOutput("inputs_sync_old", o_data_out, 8'h00);
    applyStimulus(1, 0, 1, 5'h03, 8'h00);
    checkOutput("inputs_sync_new", o_data_out, 8'h15);
`else
    @(negedge i_sys_clk);
    i_button = 1'b1; i_config = 4'b1010;
    i_cs = 1'b1; i_fetch_cmd = 1'b1; i_ioc = 5'h03;
    @(negedge i_sys_clk);
    i_cs = 1'b0; i_fetch_cmd = 1'b0;
    checkOutput("inputs_direct", o_data_out, 8'h15);
`endif
    i_button = 1'b0; i_config = 4'b0110;
    repeat (3) @(negedge i_sys_clk);
    applyStimulus(1, 0, 1, 5'h03, 8'h00);
    checkOutput("inputs_2", o_data_out, 8'h0C);

    applyStimulus(1, 1, 0, 5'h00, 8'h55);
    applyStimulus(1, 1, 0, 5'h1F, 8'hFF);
    applyStimulus(0, 1, 0, 5'h02, 8'h3C);
    checkOutput("pmod_cs_low", o_pmod, 8'h11);
    applyStimulus(1, 0, 1, 5'h00, 8'h00);
    checkOutput("rd_version_ro", o_data_out, 8'h01);
    applyStimulus(1, 0, 1, 5'h1F, 8'h00);
    checkOutput("rd_unmapped", o_data_out, 8'h00);
    applyStimulus(0, 0, 1, 5'h00, 8'h00);
    checkOutput("fetch_cs_low_holds", o_data_out, 8'h00);

    applyStimulus(1, 1, 0, 5'h05, 8'h03);
    checkOutput("mode3_pre_reset", rf_vec(), {2'b00, mode_exp[3]});
    applyStimulus(1, 0, 1, 5'h02, 8'h00);
    checkOutput("rd_pre_reset", o_data_out, 8'h11);
    #2;
    i_rst_b = 1'b0;
    #1;
    checkOutput("async_rst_rf", rf_vec(), {2'b00, mode_exp[0]});
    checkOutput("async_rst_comp", comp_vec(), 8'h03);
    checkOutput("async_rst_data", o_data_out, 8'h00);
    checkOutput("async_rst_pmod", o_pmod, 8'h00);
    checkOutput("async_rst_misc", {5'd0, o_led1, o_led0, o_mixer_fm}, 8'h00);
    @(negedge i_sys_clk);
    i_rst_b = 1'b1;
    applyStimulus(1, 0, 1, 5'h05, 8'h00);
    checkOutput("rd_mode_after_rst", o_data_out, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
